rtc_refresh_scheduler: RTL and testbench

Sequences all accesses to the shared RTC register bus for the VGA clock display. Once every FRAME_DIV frames it sweeps the nine time/date/timer registers into shadow storage and commits them atomically to the display-facing outputs, so the text renderer never shows a half-updated time. User configuration writes share the same bus and are arbitrated against the refresh sweep. It sits between the RTC bus interface and the text/VGA top, driving its cambio_*/hora_*/min_*/seg_* inputs.

---
 rtl/rtc_sched_pkg.sv | 47 ++++
 rtl/rtc_bus_watchdog.sv | 30 +++
 rtl/rtc_refresh_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_rtc_refresh_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_sched_pkg.sv
// rtc_sched_pkg -- shared types and constants for the RTC refresh scheduler.
//   state_t   : scheduler FSM states
//   NUM_REGS  : number of registers swept per refresh
//   ADDR_*    : RTC register addresses, in sweep order
//   reg_addr  : sweep index -> RTC register address
//   is_bcd    : both nibbles of a byte are decimal digits
package rtc_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRITE  = 2'd1,
      ST_READ   = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   localparam int NUM_REGS = 9;

   localparam logic [7:0] ADDR_SEG_C  = 8'h21;
   localparam logic [7:0] ADDR_MIN_C  = 8'h22;
   localparam logic [7:0] ADDR_HORA_C = 8'h23;
   localparam logic [7:0] ADDR_DIA    = 8'h24;
   localparam logic [7:0] ADDR_MES    = 8'h25;
   localparam logic [7:0] ADDR_YEAR   = 8'h26;
   localparam logic [7:0] ADDR_SEG_T  = 8'h41;
   localparam logic [7:0] ADDR_MIN_T  = 8'h42;
   localparam logic [7:0] ADDR_HORA_T = 8'h43;

   function automatic logic [7:0] reg_addr(input logic [3:0] idx);
      case (idx)
         4'd0:    reg_addr = ADDR_SEG_C;
         4'd1:    reg_addr = ADDR_MIN_C;
         4'd2:    reg_addr = ADDR_HORA_C;
         4'd3:    reg_addr = ADDR_DIA;
         4'd4:    reg_addr = ADDR_MES;
         4'd5:    reg_addr = ADDR_YEAR;
         4'd6:    reg_addr = ADDR_SEG_T;
         4'd7:    reg_addr = ADDR_MIN_T;
         4'd8:    reg_addr = ADDR_HORA_T;
         default: reg_addr = ADDR_SEG_C;
      endcase
   endfunction

   function automatic logic is_bcd(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/rtc_bus_watchdog.sv
// rtc_bus_watchdog -- counts consecutive cycles with bus_req high and flags
// a stalled transaction.
//   clk, reset : clock, synchronous active-high reset
//   bus_req    : transaction in flight
//   bus_done   : completion pulse (clears the count)
//   timeout    : high in the BUS_TIMEOUT-th cycle of an unanswered request
module rtc_bus_watchdog #(
   parameter int BUS_TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic bus_req,
   input  logic bus_done,
   output logic timeout
);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || !bus_req || bus_done)
         cnt <= 8'd0;
      else if (cnt != 8'hFF)
         cnt <= cnt + 8'd1;
   end

   // cnt is 0 in the first request cycle, so this fires exactly BUS_TIMEOUT
   // cycles into an unanswered request; the scheduler drops bus_req next.
   assign timeout = bus_req && !bus_done && (cnt == 8'(BUS_TIMEOUT - 1));

endmodule

// File: rtl/rtc_refresh_scheduler.sv
// rtc_refresh_scheduler -- owns the shared RTC register bus. Every FRAME_DIV
// frame pulses it reads the nine time/date/timer registers into shadow
// storage and commits them to the display outputs in a single cycle. User
// writes are arbitrated against the sweep and take priority.
//   clk, reset         : clock, synchronous active-high reset
//   frame_pulse        : start-of-vblank pulse
//   wr_req/addr/data   : user write (held until wr_ack), wr_ack completion
//   bus_*              : RTC bus master side (req/we/addr/wdata out,
//                        rdata/done in)
//   seg_c .. hora_t    : committed BCD values
//   update             : pulse in the cycle the committed values change
//   busy               : FSM not idle
//   err                : pulse on bus timeout or discarded sweep
// Optional: RTC_SCHED_BCD_CHECK_EN rejects sweeps containing non-BCD nibbles.
module rtc_refresh_scheduler
   import rtc_sched_pkg::*;
#(
   parameter int FRAME_DIV   = 1,
   parameter int BUS_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_pulse,
   input  logic       wr_req,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_ack,
   output logic       bus_req,
   output logic       bus_we,
   output logic [7:0] bus_addr,
   output logic [7:0] bus_wdata,
   input  logic [7:0] bus_rdata,
   input  logic       bus_done,
   output logic [7:0] seg_c,
   output logic [7:0] min_c,
   output logic [7:0] hora_c,
   output logic [7:0] cambio_dia,
   output logic [7:0] cambio_mes,
   output logic [7:0] cambio_year,
   output logic [7:0] seg_t,
   output logic [7:0] min_t,
   output logic [7:0] hora_t,
   output logic       update,
   output logic       busy,
   output logic       err
);

   state_t     state;
   logic [3:0] idx;
   logic [7:0] div_cnt;
   logic       refresh_pending;
   logic [7:0] shadow [NUM_REGS];
   logic       timeout;

   rtc_bus_watchdog #(.BUS_TIMEOUT(BUS_TIMEOUT)) u_wdog (
      .clk      (clk),
      .reset    (reset),
      .bus_req  (bus_req),
      .bus_done (bus_done),
      .timeout  (timeout)
   );

`ifdef RTC_SCHED_BCD_CHECK_EN
   logic shadow_ok;
   always_comb begin
      shadow_ok = 1'b1;
      for (int i = 0; i < NUM_REGS; i++)
         if (!is_bcd(shadow[i])) shadow_ok = 1'b0;
   end
`endif

   // Acknowledge in the completion cycle itself so a requester dropping
   // wr_req on the ack is already low when the FSM is back in IDLE.
   assign wr_ack = (state == ST_WRITE) && bus_req && bus_done;
   assign busy   = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         idx             <= 4'd0;
         div_cnt         <= 8'd0;
         refresh_pending <= 1'b0;
         bus_req         <= 1'b0;
         bus_we          <= 1'b0;
         bus_addr        <= 8'd0;
         bus_wdata       <= 8'd0;
         update          <= 1'b0;
         err             <= 1'b0;
         seg_c           <= 8'd0;
         min_c           <= 8'd0;
         hora_c          <= 8'd0;
         cambio_dia      <= 8'd0;
         cambio_mes      <= 8'd0;
         cambio_year     <= 8'd0;
         seg_t           <= 8'd0;
         min_t           <= 8'd0;
         hora_t          <= 8'd0;
         for (int i = 0; i < NUM_REGS; i++) shadow[i] <= 8'd0;
      end else begin
         update <= 1'b0;
         err    <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (wr_req) begin
                  state     <= ST_WRITE;
                  bus_req   <= 1'b1;
                  bus_we    <= 1'b1;
                  bus_addr  <= wr_addr;
                  bus_wdata <= wr_data;
               end else if (refresh_pending) begin
                  state           <= ST_READ;
                  idx             <= 4'd0;
                  bus_req         <= 1'b1;
                  bus_we          <= 1'b0;
                  bus_addr        <= ADDR_SEG_C;
                  refresh_pending <= 1'b0;
               end
            end

            ST_WRITE: begin
               // Entered from READ with bus_req low: this is the mandatory
               // idle cycle after the preceding read completed.
               if (!bus_req) begin
                  bus_req <= 1'b1;
               end else if (timeout) begin
                  bus_req <= 1'b0;
                  err     <= 1'b1;
                  state   <= ST_IDLE;
               end else if (bus_done) begin
                  bus_req <= 1'b0;
                  state   <= ST_IDLE;
               end
            end

            ST_READ: begin
               // bus_req low inside READ is the gap cycle between reads.
               if (!bus_req) begin
                  bus_req  <= 1'b1;
                  bus_addr <= reg_addr(idx);
               end else if (timeout) begin
                  bus_req <= 1'b0;
                  err     <= 1'b1;
                  state   <= ST_IDLE;
               end else if (bus_done) begin
                  shadow[idx] <= bus_rdata;
                  bus_req     <= 1'b0;
                  if (idx == 4'(NUM_REGS - 1)) begin
                     // A complete sweep commits first; a waiting write is
                     // picked up from IDLE two cycles later.
                     state <= ST_COMMIT;
                  end else if (wr_req) begin
                     // Yield to the user write and restart the sweep later.
                     state           <= ST_WRITE;
                     refresh_pending <= 1'b1;
                     bus_we          <= 1'b1;
                     bus_addr        <= wr_addr;
                     bus_wdata       <= wr_data;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end

            ST_COMMIT: begin
               state <= ST_IDLE;
`ifdef RTC_SCHED_BCD_CHECK_EN
               if (!shadow_ok) begin
                  err <= 1'b1;
               end else
`endif
               begin
                  seg_c       <= shadow[0];
                  min_c       <= shadow[1];
                  hora_c      <= shadow[2];
                  cambio_dia  <= shadow[3];
                  cambio_mes  <= shadow[4];
                  cambio_year <= shadow[5];
                  seg_t       <= shadow[6];
                  min_t       <= shadow[7];
                  hora_t      <= shadow[8];
                  update      <= 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase

         // Placed after the FSM so a wrap coinciding with a sweep start
         // re-arms the flag rather than being lost.
         if (frame_pulse) begin
            if (div_cnt == 8'(FRAME_DIV - 1)) begin
               div_cnt         <= 8'd0;
               refresh_pending <= 1'b1;
            end else begin
               div_cnt <= div_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rtc_refresh_scheduler.sv
// tb_rtc_refresh_scheduler -- self-checking bench. Instance 0 uses
// FRAME_DIV=1/BUS_TIMEOUT=16, instance 1 uses FRAME_DIV=3. Each instance
// has a bus model answering in the third request cycle with data from
// data_tab, optionally never answering one read address.
module tb_rtc_refresh_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       frame_pulse [2];
   logic       wr_req      [2];
   logic [7:0] wr_addr     [2];
   logic [7:0] wr_data     [2];
   logic       wr_ack      [2];
   logic       bus_req     [2];
   logic       bus_we      [2];
   logic [7:0] bus_addr    [2];
   logic [7:0] bus_wdata   [2];
   logic [7:0] bus_rdata   [2];
   logic       bus_done    [2];
   logic [7:0] outv        [2][9];
   logic       update      [2];
   logic       busy        [2];
   logic       err         [2];

   logic [8:0][7:0] data_tab  [2];
   logic            hang_en   [2];
   logic [7:0]      hang_addr [2];

   int checks = 0;
   int errors = 0;

   rtc_refresh_scheduler #(.FRAME_DIV(1), .BUS_TIMEOUT(16)) u_a (
      .clk(clk), .reset(reset), .frame_pulse(frame_pulse[0]),
      .wr_req(wr_req[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_ack(wr_ack[0]),
      .bus_req(bus_req[0]), .bus_we(bus_we[0]), .bus_addr(bus_addr[0]), .bus_wdata(bus_wdata[0]),
      .bus_rdata(bus_rdata[0]), .bus_done(bus_done[0]),
      .seg_c(outv[0][0]), .min_c(outv[0][1]), .hora_c(outv[0][2]), .cambio_dia(outv[0][3]),
      .cambio_mes(outv[0][4]), .cambio_year(outv[0][5]), .seg_t(outv[0][6]), .min_t(outv[0][7]),
      .hora_t(outv[0][8]), .update(update[0]), .busy(busy[0]), .err(err[0]));

   rtc_refresh_scheduler #(.FRAME_DIV(3)) u_b (
      .clk(clk), .reset(reset), .frame_pulse(frame_pulse[1]),
      .wr_req(wr_req[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_ack(wr_ack[1]),
      .bus_req(bus_req[1]), .bus_we(bus_we[1]), .bus_addr(bus_addr[1]), .bus_wdata(bus_wdata[1]),
      .bus_rdata(bus_rdata[1]), .bus_done(bus_done[1]),
      .seg_c(outv[1][0]), .min_c(outv[1][1]), .hora_c(outv[1][2]), .cambio_dia(outv[1][3]),
      .cambio_mes(outv[1][4]), .cambio_year(outv[1][5]), .seg_t(outv[1][6]), .min_t(outv[1][7]),
      .hora_t(outv[1][8]), .update(update[1]), .busy(busy[1]), .err(err[1]));

   function automatic int idx_of(input logic [7:0] a);
      case (a)
         8'h21: return 0;
         8'h22: return 1;
         8'h23: return 2;
         8'h24: return 3;
         8'h25: return 4;
         8'h26: return 5;
         8'h41: return 6;
         8'h42: return 7;
         8'h43: return 8;
         default: return 0;
      endcase
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_bus
      logic        done = 1'b0;
      int          lat = 0;
      int          log_n = 0;
      logic [16:0] log_e [64];
      int          upd_n = 0, err_n = 0, ack_n = 0, viol = 0;
      logic        p_done = 1'b0, p_req = 1'b0, p_we = 1'b0;
      logic [7:0]  p_addr = 8'd0, p_wdata = 8'd0;

      assign bus_done[k]  = done;
      assign bus_rdata[k] = data_tab[k][idx_of(bus_addr[k])];

      always @(posedge clk) begin
         if (done) begin
            done <= 1'b0;
         end else if (bus_req[k] && !(hang_en[k] && !bus_we[k] && bus_addr[k] == hang_addr[k])) begin
            if (lat == 1) begin
               done <= 1'b1;
               lat  <= 0;
               if (log_n < 64) begin
                  log_e[log_n] <= {bus_we[k], bus_addr[k], bus_wdata[k]};
                  log_n        <= log_n + 1;
               end
            end else begin
               lat <= lat + 1;
            end
         end else begin
            lat <= 0;
         end
      end

      // Event counters plus bus protocol monitor: request must drop the
      // cycle after a completion, and its fields must hold while it is high.
      always @(negedge clk) begin
         if (update[k]) upd_n <= upd_n + 1;
         if (err[k])    err_n <= err_n + 1;
         if (wr_ack[k]) ack_n <= ack_n + 1;
         if (!reset) begin
            if (p_done && p_req && bus_req[k]) viol <= viol + 1;
            if (p_req && bus_req[k] && (bus_addr[k] != p_addr || bus_we[k] != p_we ||
                (bus_we[k] && bus_wdata[k] != p_wdata)))
               viol <= viol + 1;
         end
         p_done  <= bus_done[k];
         p_req   <= bus_req[k];
         p_we    <= bus_we[k];
         p_addr  <= bus_addr[k];
         p_wdata <= bus_wdata[k];
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic pulse_frame(input int k);
      frame_pulse[k] = 1'b1;
      tick();
      frame_pulse[k] = 1'b0;
   endtask

   typedef struct packed {
      logic [8:0][7:0] rd;
      logic [8:0][7:0] exp;
      logic            upd;
   } vec_t;

   vec_t vt [3];

   initial begin
      int u0, e0, l0, a0, n;
      bit seen;
      logic [8:0] seq [15];

      // table: read data, expected committed outputs (index 8 first), update
      vt[0].rd  = {8'h18, 8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
      vt[0].exp = {8'h18, 8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
      vt[0].upd = 1'b1;
      vt[1].rd  = {8'h07, 8'h30, 8'h45, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59};
      vt[1].exp = {8'h07, 8'h30, 8'h45, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59};
      vt[1].upd = 1'b1;
      vt[2].rd  = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h5A};
`ifdef RTC_SCHED_BCD_CHECK_EN
      vt[2].exp = {8'h07, 8'h30, 8'h45, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59};
      vt[2].upd = 1'b0;
`else
      vt[2].exp = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h5A};
      vt[2].upd = 1'b1;
`endif

      seq = '{9'h021, 9'h022, 9'h023, 9'h024, 9'h025, 9'h130, 9'h021, 9'h022,
              9'h023, 9'h024, 9'h025, 9'h026, 9'h041, 9'h042, 9'h043};

      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         frame_pulse[k] = 1'b0; wr_req[k] = 1'b0; wr_addr[k] = 8'd0; wr_data[k] = 8'd0;
         data_tab[k] = '0; hang_en[k] = 1'b0; hang_addr[k] = 8'd0;
      end
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // reset state
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 9; i++) chk($sformatf("rst%0d_out%0d", k, i), outv[k][i], 8'h00);
         chk($sformatf("rst%0d_busreq", k), bus_req[k], 1'b0);
         chk($sformatf("rst%0d_busy", k), busy[k], 1'b0);
         chk($sformatf("rst%0d_upd", k), update[k], 1'b0);
         chk($sformatf("rst%0d_err", k), err[k], 1'b0);
      end

      // table-driven sweeps on instance 0
      for (int v = 0; v < 3; v++) begin
         data_tab[0] = vt[v].rd;
         u0 = g_bus[0].upd_n; e0 = g_bus[0].err_n; l0 = g_bus[0].log_n;
         pulse_frame(0);
         chk($sformatf("v%0d_req_n1", v), bus_req[0], 1'b0);
         tick();
         chk($sformatf("v%0d_req_n2", v), bus_req[0], 1'b1);
         seen = 0;
         for (int t = 0; t < 200 && !seen; t++) begin
            tick();
            if (g_bus[0].upd_n != u0 || g_bus[0].err_n != e0) seen = 1;
         end
         chk($sformatf("v%0d_done_wait", v), seen, 1'b1);
         tick();
         chk($sformatf("v%0d_upd_cnt", v), g_bus[0].upd_n - u0, vt[v].upd);
         chk($sformatf("v%0d_err_cnt", v), g_bus[0].err_n - e0, !vt[v].upd);
         chk($sformatf("v%0d_upd_low", v), update[0], 1'b0);
         for (int i = 0; i < 9; i++)
            chk($sformatf("v%0d_out%0d", v, i), outv[0][i], vt[v].exp[i]);
         if (v == 0) begin
            chk("v0_nreads", g_bus[0].log_n - l0, 9);
            for (int i = 0; i < 9; i++)
               chk($sformatf("v0_rd%0d", i), g_bus[0].log_e[l0 + i][16:8], seq[6 + i]);
         end
      end

      // single user write while idle
      u0 = g_bus[0].upd_n; l0 = g_bus[0].log_n; a0 = g_bus[0].ack_n;
      wr_addr[0] = 8'h22; wr_data[0] = 8'h45; wr_req[0] = 1'b1;
      seen = 0;
      for (int t = 0; t < 50 && !seen; t++) begin
         tick();
         if (wr_ack[0]) begin seen = 1; wr_req[0] = 1'b0; end
      end
      chk("wr_ack_seen", seen, 1'b1);
      tick();
      chk("wr_ack_pulse", wr_ack[0], 1'b0);
      repeat (5) tick();
      chk("wr_ack_cnt", g_bus[0].ack_n - a0, 1);
      chk("wr_ntxn", g_bus[0].log_n - l0, 1);
      chk("wr_txn", g_bus[0].log_e[l0], {1'b1, 8'h22, 8'h45});
      chk("wr_no_upd", g_bus[0].upd_n - u0, 0);
      chk("wr_idle", busy[0], 1'b0);

      // write arriving during read index 4 preempts and restarts the sweep
      for (int i = 0; i < 9; i++) data_tab[0][i] = 8'h20 + 8'(i);
      u0 = g_bus[0].upd_n; l0 = g_bus[0].log_n; a0 = g_bus[0].ack_n;
      pulse_frame(0);
      seen = 0;
      for (int t = 0; t < 100 && !seen; t++) begin
         tick();
         if (bus_req[0] && !bus_we[0] && bus_addr[0] == 8'h25) seen = 1;
      end
      chk("pre_find_idx4", seen, 1'b1);
      wr_addr[0] = 8'h30; wr_data[0] = 8'h77; wr_req[0] = 1'b1;
      seen = 0;
      for (int t = 0; t < 300 && !seen; t++) begin
         tick();
         if (wr_ack[0]) wr_req[0] = 1'b0;
         if (g_bus[0].upd_n != u0) seen = 1;
      end
      wr_req[0] = 1'b0;
      chk("pre_upd_wait", seen, 1'b1);
      repeat (3) tick();
      chk("pre_upd_cnt", g_bus[0].upd_n - u0, 1);
      chk("pre_ack_cnt", g_bus[0].ack_n - a0, 1);
      chk("pre_ntxn", g_bus[0].log_n - l0, 15);
      for (int i = 0; i < 15; i++)
         chk($sformatf("pre_txn%0d", i), g_bus[0].log_e[l0 + i][16:8], seq[i]);
      chk("pre_wdata", g_bus[0].log_e[l0 + 5][7:0], 8'h77);
      for (int i = 0; i < 9; i++)
         chk($sformatf("pre_out%0d", i), outv[0][i], 8'h20 + 8'(i));

      // bus never answers the read of 8'h23
      for (int i = 0; i < 9; i++) data_tab[0][i] = 8'h30 + 8'(i);
      hang_en[0] = 1'b1; hang_addr[0] = 8'h23;
      u0 = g_bus[0].upd_n; e0 = g_bus[0].err_n;
      pulse_frame(0);
      seen = 0;
      for (int t = 0; t < 100 && !seen; t++) begin
         tick();
         if (bus_req[0] && bus_addr[0] == 8'h23) seen = 1;
      end
      chk("to_find_23", seen, 1'b1);
      n = 0;
      while (bus_req[0] && n < 40) begin
         n++;
         tick();
      end
      chk("to_req_cycles", n, 16);
      chk("to_err_pulse", err[0], 1'b1);
      tick();
      chk("to_err_low", err[0], 1'b0);
      repeat (10) tick();
      chk("to_err_cnt", g_bus[0].err_n - e0, 1);
      chk("to_no_upd", g_bus[0].upd_n - u0, 0);
      chk("to_idle", busy[0], 1'b0);
      for (int i = 0; i < 9; i++)
         chk($sformatf("to_out%0d", i), outv[0][i], 8'h20 + 8'(i));
      hang_en[0] = 1'b0;

      // FRAME_DIV=3: six pulses give two sweeps
      for (int i = 0; i < 9; i++) data_tab[1][i] = 8'h40 + 8'(i);
      u0 = g_bus[1].upd_n;
      for (int p = 0; p < 6; p++) begin
         pulse_frame(1);
         repeat (60) tick();
         if (p == 1) chk("div_after2", g_bus[1].upd_n - u0, 0);
         if (p == 2) chk("div_after3", g_bus[1].upd_n - u0, 1);
      end
      chk("div_after6", g_bus[1].upd_n - u0, 2);
      chk("div_hora_t", outv[1][8], 8'h48);
      chk("div_seg_c", outv[1][0], 8'h40);

      // reset in the middle of a sweep
      for (int i = 0; i < 9; i++) data_tab[0][i] = 8'h50 + 8'(i);
      u0 = g_bus[0].upd_n;
      pulse_frame(0);
      seen = 0;
      for (int t = 0; t < 100 && !seen; t++) begin
         tick();
         if (bus_req[0] && bus_addr[0] == 8'h24) seen = 1;
      end
      chk("mr_find_24", seen, 1'b1);
      reset = 1'b1;
      tick();
      chk("mr_req_low", bus_req[0], 1'b0);
      chk("mr_busy", busy[0], 1'b0);
      reset = 1'b0;
      repeat (60) tick();
      chk("mr_no_upd", g_bus[0].upd_n - u0, 0);
      chk("mr_seg_c", outv[0][0], 8'h00);
      chk("mr_hora_t", outv[0][8], 8'h00);

      chk("proto0", g_bus[0].viol, 0);
      chk("proto1", g_bus[1].viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
